player_sprite: RTL and testbench

- Atari-style player object generator: one 8-bit graphic, drawn once per scanline at a programmable horizontal position, with reflect and 3 horizontal scales.
- Sits upstream of the peripherals colour mux. It is written from the CPU register bus, and its pixel_on/pixel_color outputs are merged over the playfield colour before the HDMI stage.
- Also latches a player/playfield collision flag that the CPU reads back.

---
 rtl/player_sprite_if.sv | 24 ++
 rtl/player_sprite.sv | 152 +++++++++++++++
 tb/tb_player_sprite.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_sprite_if.sv
// CPU register bus for the player sprite: one-cycle write strobe with
// select/data, plus the registered read-back byte.
interface player_sprite_if;
    logic       write_enable;
    logic [2:0] reg_sel;
    logic [7:0] data_in;
    logic [7:0] data_out;

    // CPU side drives the writes and samples the read-back byte.
    modport master (
        output write_enable,
        output reg_sel,
        output data_in,
        input  data_out
    );

    // Sprite side decodes the writes and returns the collision byte.
    modport slave (
        input  write_enable,
        input  reg_sel,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/player_sprite.sv
// Atari-style player object: one 8-bit graphic drawn once per scanline at a
// programmable x position, with reflect, 3 horizontal scales and a sticky
// player/playfield collision flag readable over the CPU bus.
module player_sprite #(
    parameter int XPOS_W  = 10,
    parameter int COLOR_W = 7
) (
    input  logic               raw_clk,
    input  logic               reset,
    player_sprite_if.slave     bus,
    input  logic               pixel_strobe,
    input  logic [XPOS_W-1:0]  hpos,
    input  logic               in_image,
    input  logic               playfield_fg,
    output logic               pixel_on,
    output logic [COLOR_W-1:0] pixel_color,
    output logic               collision
);

    typedef enum logic {IDLE, DRAW} state_t;

    // CPU-visible registers
    logic [7:0]         graphic;
    logic [XPOS_W-1:0]  x_pos;
    logic [COLOR_W-1:0] color;
    logic               reflect;
    logic [1:0]         size;

    // Per-line copies captured when a draw starts
    state_t     state;
    logic [7:0] shadow;
    logic       sh_reflect;
    logic [3:0] sh_last;
    logic [2:0] bit_idx;
    logic [3:0] sub_cnt;

    logic       sub_wrap;
    logic       line_done;
    logic [2:0] nxt_idx;
    logic       draw_bit;
    logic       start_bit;
    logic       clear_wr;

    // Last sub-pixel index of one graphic bit: W-1 for W = 4, 8, 16.
    function automatic logic [3:0] scale_last(input logic [1:0] s);
        unique case (s)
            2'b00:   return 4'd3;
            2'b01:   return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

    assign clear_wr = bus.write_enable && (bus.reg_sel == 3'd5);

    // Decode CPU register writes; select 5 is handled with the collision flag.
    // NOTE: every register here is a flip-flop (no RAM), so the async reset
    // clears all of them, including the shadow graphic below.
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            graphic <= '0;
            x_pos   <= '0;
            color   <= '0;
            reflect <= 1'b0;
            size    <= '0;
        end else if (bus.write_enable) begin
            // NOTE: sequential state always uses non-blocking assignments so
            // every register samples pre-edge values regardless of order.
            unique case (bus.reg_sel)
                3'd0: graphic           <= bus.data_in;
                3'd1: x_pos[7:0]        <= bus.data_in;
                3'd2: x_pos[XPOS_W-1:8] <= bus.data_in[XPOS_W-9:0];
                3'd3: color             <= COLOR_W'(bus.data_in[7:1]);
                3'd4: begin
                    reflect <= bus.data_in[0];
                    size    <= bus.data_in[2:1];
                end
                default: ;
            endcase
        end
    end

    // Next graphic bit to show: advance the bit index when the scale counter wraps.
    always_comb begin
        sub_wrap  = (sub_cnt == sh_last);
        line_done = sub_wrap && (bit_idx == 3'd7);
        nxt_idx   = sub_wrap ? bit_idx + 3'd1 : bit_idx;
        draw_bit  = sh_reflect ? shadow[nxt_idx] : shadow[3'd7 - nxt_idx];
        start_bit = reflect ? graphic[0] : graphic[7];
    end

    // Draw FSM with registered pixel outputs; it only moves on pixel strobes.
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shadow      <= '0;
            sh_reflect  <= 1'b0;
            sh_last     <= '0;
            bit_idx     <= '0;
            sub_cnt     <= '0;
            pixel_on    <= 1'b0;
            pixel_color <= '0;
        end else if (pixel_strobe) begin
            unique case (state)
                IDLE: begin
                    if (in_image && (hpos == x_pos)) begin
                        state       <= DRAW;
                        shadow      <= graphic;
                        sh_reflect  <= reflect;
                        sh_last     <= scale_last(size);
                        bit_idx     <= '0;
                        sub_cnt     <= '0;
                        pixel_on    <= start_bit;
                        pixel_color <= start_bit ? color : '0;
                    end else begin
                        pixel_on    <= 1'b0;
                        pixel_color <= '0;
                    end
                end
                DRAW: begin
                    // Leaving the picture truncates the sprite; it never wraps.
                    if (!in_image || line_done) begin
                        state       <= IDLE;
                        pixel_on    <= 1'b0;
                        pixel_color <= '0;
                    end else begin
                        bit_idx     <= nxt_idx;
                        sub_cnt     <= sub_wrap ? 4'd0 : sub_cnt + 4'd1;
                        pixel_on    <= draw_bit;
                        pixel_color <= draw_bit ? color : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky collision flag (set beats clear) and its registered read-back byte.
    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            collision    <= 1'b0;
            bus.data_out <= '0;
        end else begin
            if (pixel_strobe && pixel_on && playfield_fg) begin
                collision <= 1'b1;
            end else if (clear_wr) begin
                collision <= 1'b0;
            end
            bus.data_out <= {7'b0, collision};
        end
    end

endmodule

// File: tb/tb_player_sprite.sv
// Testbench for player_sprite: directed scanlines plus random lines, every
// cycle compared against an offset-based behavioural model of the sprite.
module tb_player_sprite;

    logic       raw_clk;
    logic       reset;
    logic       pixel_strobe;
    logic [9:0] hpos;
    logic       in_image;
    logic       playfield_fg;
    logic       pixel_on;
    logic [6:0] pixel_color;
    logic       collision;

    player_sprite_if bus ();

    player_sprite dut (
        .raw_clk      (raw_clk),
        .reset        (reset),
        .bus          (bus),
        .pixel_strobe (pixel_strobe),
        .hpos         (hpos),
        .in_image     (in_image),
        .playfield_fg (playfield_fg),
        .pixel_on     (pixel_on),
        .pixel_color  (pixel_color),
        .collision    (collision)
    );

    initial raw_clk = 1'b0;
    always #5 raw_clk = ~raw_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: registers, current draw (start hpos, captured graphic,
    // reflect and width), expected outputs.
    logic [7:0] m_gfx;
    logic [9:0] m_x;
    logic [6:0] m_color;
    logic       m_refl;
    logic [1:0] m_size;
    logic       m_active;
    int         m_start;
    logic [7:0] m_sg;
    logic       m_sr;
    int         m_w;
    logic       m_on;
    logic [6:0] m_pcol;
    logic       m_col;
    logic [7:0] m_dout;

    // Lit-pixel statistics of the current line, taken from the DUT outputs.
    int lit_cnt;
    int lit_first;
    int lit_last;

    task automatic model_reset();
        m_gfx = '0; m_x = '0; m_color = '0; m_refl = 1'b0; m_size = '0;
        m_active = 1'b0; m_start = 0; m_sg = '0; m_sr = 1'b0; m_w = 4;
        m_on = 1'b0; m_pcol = '0; m_col = 1'b0; m_dout = '0;
    endtask

    task automatic clear_stats();
        lit_cnt = 0; lit_first = -1; lit_last = -1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge of the model; register writes land after the strobe logic.
    task automatic model_edge(input logic stb, input int h, input logic ii, input logic pf,
                              input logic we, input logic [2:0] sel, input logic [7:0] d);
        logic old_on;
        logic new_on;
        int   off;
        int   i;
        old_on = m_on;
        m_dout = {7'b0, m_col};
        if (stb && old_on && pf) m_col = 1'b1;
        else if (we && sel == 3'd5) m_col = 1'b0;
        if (stb) begin
            new_on = 1'b0;
            if (m_active) begin
                off = h - m_start;
                if (!ii || off >= 8 * m_w) begin
                    m_active = 1'b0;
                end else begin
                    i = off / m_w;
                    new_on = m_sr ? m_sg[i] : m_sg[7 - i];
                end
            end else if (ii && h == int'(m_x)) begin
                m_active = 1'b1;
                m_start  = h;
                m_sg     = m_gfx;
                m_sr     = m_refl;
                m_w      = (m_size == 2'd0) ? 4 : (m_size == 2'd1) ? 8 : 16;
                new_on   = m_sr ? m_sg[0] : m_sg[7];
            end
            m_on   = new_on;
            m_pcol = new_on ? m_color : 7'd0;
        end
        if (we) begin
            case (sel)
                3'd0: m_gfx = d;
                3'd1: m_x[7:0] = d;
                3'd2: m_x[9:8] = d[1:0];
                3'd3: m_color = d[7:1];
                3'd4: begin m_refl = d[0]; m_size = d[2:1]; end
                default: ;
            endcase
        end
    endtask

    // Drive one raw_clk cycle, then compare all outputs 1 time unit after the edge.
    task automatic cycle(input logic stb, input int h, input logic ii, input logic pf,
                         input logic we, input logic [2:0] sel, input logic [7:0] d);
        @(negedge raw_clk);
        pixel_strobe     = stb;
        hpos             = 10'(h);
        in_image         = ii;
        playfield_fg     = pf;
        bus.write_enable = we;
        bus.reg_sel      = sel;
        bus.data_in      = d;
        @(posedge raw_clk);
        #1;
        model_edge(stb, h, ii, pf, we, sel, d);
        check("pixel_on", 32'(pixel_on), 32'(m_on));
        check("pixel_color", 32'(pixel_color), 32'(m_pcol));
        check("collision", 32'(collision), 32'(m_col));
        check("data_out", 32'(bus.data_out), 32'(m_dout));
        if (stb && pixel_on === 1'b1) begin
            if (lit_first < 0) lit_first = h;
            lit_last = h;
            lit_cnt++;
        end
    endtask

    task automatic wr(input logic [2:0] sel, input logic [7:0] d);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, sel, d);
    endtask

    // Scan hpos h0..h1 with a strobe cycle followed by an idle (hold) cycle;
    // an optional register write rides on the strobe at hpos wh.
    task automatic scan(input int h0, input int h1, input int pf_lo, input int pf_hi,
                        input int wh, input logic [2:0] wsel, input logic [7:0] wd);
        logic ii;
        logic pf;
        for (int h = h0; h <= h1; h++) begin
            ii = (h < 720);
            pf = (h >= pf_lo) && (h <= pf_hi);
            cycle(1'b1, h, ii, pf, h == wh, wsel, wd);
            cycle(1'b0, h, ii, pf, 1'b0, 3'd0, 8'd0);
        end
    endtask

    task automatic line(input int pf_lo, input int pf_hi, input int wh,
                        input logic [2:0] wsel, input logic [7:0] wd);
        clear_stats();
        scan(0, 799, pf_lo, pf_hi, wh, wsel, wd);
    endtask

    task automatic basic_regs();
        wr(3'd0, 8'h81);
        wr(3'd1, 8'd100);
        wr(3'd2, 8'd0);
        wr(3'd3, 8'h54);
        wr(3'd4, 8'h00);
    endtask

    initial begin
        logic [9:0] rx;
        int         lo;
        model_reset();
        clear_stats();
        reset            = 1'b0;
        pixel_strobe     = 1'b0;
        hpos             = '0;
        in_image         = 1'b0;
        playfield_fg     = 1'b0;
        bus.write_enable = 1'b0;
        bus.reg_sel      = '0;
        bus.data_in      = '0;
        #1;
        check("reset_pixel_on", 32'(pixel_on), 32'd0);
        check("reset_pixel_color", 32'(pixel_color), 32'd0);
        check("reset_collision", 32'(collision), 32'd0);
        check("reset_data_out", 32'(bus.data_out), 32'd0);
        @(negedge raw_clk);
        @(negedge raw_clk);
        reset = 1'b1;

        // Basic draw: lit 100..103 and 128..131, colour 0x2A.
        basic_regs();
        line(-1, -1, -1, 3'd0, 8'd0);
        check("basic_count", 32'(lit_cnt), 32'd8);
        check("basic_first", 32'(lit_first), 32'd100);
        check("basic_last", 32'(lit_last), 32'd131);

        // Graphic write mid-draw only affects the next line.
        line(-1, -1, 110, 3'd0, 8'hFF);
        check("midline_count", 32'(lit_cnt), 32'd8);
        check("midline_last", 32'(lit_last), 32'd131);
        line(-1, -1, -1, 3'd0, 8'd0);
        check("nextline_count", 32'(lit_cnt), 32'd32);
        check("nextline_first", 32'(lit_first), 32'd100);
        check("nextline_last", 32'(lit_last), 32'd131);

        // Reflect with size 01: bits 6,7 appear at 248..263.
        wr(3'd0, 8'hC0);
        wr(3'd4, 8'b0000_0011);
        wr(3'd1, 8'd200);
        line(-1, -1, -1, 3'd0, 8'd0);
        check("reflect_count", 32'(lit_cnt), 32'd16);
        check("reflect_first", 32'(lit_first), 32'd248);
        check("reflect_last", 32'(lit_last), 32'd263);

        // Edge truncation at x=710, size 10.
        wr(3'd0, 8'hFF);
        wr(3'd4, 8'b0000_0100);
        wr(3'd1, 8'hC6);
        wr(3'd2, 8'h02);
        line(-1, -1, -1, 3'd0, 8'd0);
        check("edge_count", 32'(lit_cnt), 32'd10);
        check("edge_first", 32'(lit_first), 32'd710);
        check("edge_last", 32'(lit_last), 32'd719);
        line(-1, -1, -1, 3'd0, 8'd0);
        check("edge_nowrap_first", 32'(lit_first), 32'd710);

        // Collision with playfield over 96..111, then clear, then clear vs set.
        basic_regs();
        wr(3'd2, 8'h00);
        line(96, 111, -1, 3'd0, 8'd0);
        check("coll_set", 32'(collision), 32'd1);
        check("coll_data_out", 32'(bus.data_out), 32'h01);
        wr(3'd5, 8'h00);
        check("coll_cleared", 32'(collision), 32'd0);
        wr(3'd6, 8'h00);
        check("coll_data_out_cleared", 32'(bus.data_out), 32'h00);
        line(96, 111, 101, 3'd5, 8'h00);
        check("coll_set_wins", 32'(collision), 32'd1);

        // Async reset in the middle of a draw, between strobes.
        clear_stats();
        scan(0, 101, 96, 111, -1, 3'd0, 8'd0);
        check("pre_reset_pixel_on", 32'(pixel_on), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_pixel_on", 32'(pixel_on), 32'd0);
        check("async_pixel_color", 32'(pixel_color), 32'd0);
        check("async_collision", 32'(collision), 32'd0);
        model_reset();
        @(negedge raw_clk);
        reset = 1'b1;
        line(0, 799, -1, 3'd0, 8'd0);
        check("post_reset_count", 32'(lit_cnt), 32'd0);

        // Random lines with random registers, playfield window and mid-line writes.
        for (int n = 0; n < 8; n++) begin
            rx = 10'($urandom_range(0, 760));
            wr(3'd0, 8'($urandom));
            wr(3'd1, rx[7:0]);
            wr(3'd2, {6'd0, rx[9:8]});
            wr(3'd3, 8'($urandom));
            wr(3'd4, 8'($urandom));
            if ($urandom_range(0, 1) == 1) wr(3'd5, 8'd0);
            lo = $urandom_range(0, 799);
            line(lo, lo + $urandom_range(0, 40), $urandom_range(0, 799),
                 3'($urandom_range(0, 7)), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
